cpu_trace_monitor: RTL

CPU_TRACE_MONITOR -- requirements
Module: cpu_trace_monitor

---
 rtl/cpu_trace_monitor.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/cpu_trace_monitor.sv
// Observes a small CPU's controller state and registers: it snapshots the register file on IDLE
// into a trace FIFO, detects a self-jump halt, counts executed instructions and runs a watchdog.
module cpu_trace_monitor #(
  parameter int unsigned         DATA_W      = 8,
  parameter int unsigned         STATE_W     = 6,
  parameter logic [STATE_W-1:0]  IDLE_CODE   = 6'b100000,
  parameter logic [STATE_W-1:0]  EXEC_CODE   = 6'b001000,
  parameter int unsigned         DEPTH       = 4,
  parameter int unsigned         HALT_REPEAT = 1,
  parameter int unsigned         CNT_W       = 16,
  parameter int unsigned         WDOG_LIMIT  = 1000
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       clear,
  input  logic [STATE_W-1:0]         state,
  input  logic [1:0]                 op,
  input  logic [DATA_W-1:0]          rA,
  input  logic [DATA_W-1:0]          rB,
  input  logic [DATA_W-1:0]          rM,
  input  logic [DATA_W-1:0]          rP,
  output logic [4*DATA_W-1:0]        trace_data,
  output logic                       trace_valid,
  input  logic                       trace_ready,
  output logic [$clog2(DEPTH):0]     trace_level,
  output logic [7:0]                 drop_count,
  output logic                       halted,
  output logic [DATA_W-1:0]          halt_pc,
  output logic [CNT_W-1:0]           instr_count,
  output logic                       wdog_timeout
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LVL_W   = PTR_W + 1;
  localparam int unsigned RUN_W   = $clog2(HALT_REPEAT + 1);
  localparam int unsigned ENTRY_W = 4 * DATA_W;

  logic [ENTRY_W-1:0] mem_q [DEPTH];
  logic [ENTRY_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]   level_q, level_d;
  logic [7:0]         drop_q, drop_d;
  logic [RUN_W-1:0]   run_q, run_d;
  logic               halted_q, halted_d;
  logic [DATA_W-1:0]  halt_pc_q, halt_pc_d;
  logic [CNT_W-1:0]   icnt_q, icnt_d;
  logic [CNT_W-1:0]   wdog_q, wdog_d;
  logic               timeout_q, timeout_d;

  logic is_idle, is_exec, match, full, pop, push_ok, drop_evt, halt_hit, wdog_run;

  always_comb begin
    is_idle  = (state == IDLE_CODE);
    is_exec  = (state == EXEC_CODE);
    match    = is_exec && (op == 2'b11) && ((rP - DATA_W'(1)) == rM);
    full     = (level_q == LVL_W'(DEPTH));
    pop      = (level_q != '0) && trace_ready;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    push_ok  = is_idle && (!full || pop);
    drop_evt = is_idle && full && !pop;
    halt_hit = match && !halted_q && (run_q == RUN_W'(HALT_REPEAT - 1));
    wdog_run = !is_idle && !halted_q && !timeout_q;
  end

  // Trace FIFO: storage, pointers and occupancy; unaffected by clear.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = {rA, rB, rM, rP};
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      level_d = level_q + LVL_W'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - LVL_W'(1);
    end
  end

  // Halt detector, instruction counter, watchdog and drop counter.
  always_comb begin
    drop_d    = drop_q;
    run_d     = run_q;
    halted_d  = halted_q;
    halt_pc_d = halt_pc_q;
    icnt_d    = icnt_q;
    wdog_d    = wdog_q;
    timeout_d = timeout_q;

    if (drop_evt && (drop_q != 8'hFF)) begin
      drop_d = drop_q + 8'd1;
    end

    if (is_exec) begin
      if (!match) begin
        run_d = '0;
      end else if (run_q != RUN_W'(HALT_REPEAT)) begin
        run_d = run_q + RUN_W'(1);
      end
    end

    if (halt_hit) begin
      halted_d  = 1'b1;
      halt_pc_d = rM;
    end

    if (is_exec && !halted_q && (icnt_q != '1)) begin
      icnt_d = icnt_q + CNT_W'(1);
    end

    if (is_idle) begin
      wdog_d = '0;
    end else if (wdog_run) begin
      wdog_d = wdog_q + CNT_W'(1);
      if (wdog_q == CNT_W'(WDOG_LIMIT - 1)) begin
        timeout_d = 1'b1;
      end
    end

    if (clear) begin
      drop_d    = '0;
      run_d     = '0;
      halted_d  = 1'b0;
      halt_pc_d = '0;
      icnt_d    = '0;
      wdog_d    = '0;
      timeout_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      drop_q    <= '0;
      run_q     <= '0;
      halted_q  <= 1'b0;
      halt_pc_q <= '0;
      icnt_q    <= '0;
      wdog_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      mem_q     <= mem_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      drop_q    <= drop_d;
      run_q     <= run_d;
      halted_q  <= halted_d;
      halt_pc_q <= halt_pc_d;
      icnt_q    <= icnt_d;
      wdog_q    <= wdog_d;
      timeout_q <= timeout_d;
    end
  end

  assign trace_data   = mem_q[rd_ptr_q];
  assign trace_valid  = (level_q != '0);
  assign trace_level  = level_q;
  assign drop_count   = drop_q;
  assign halted       = halted_q;
  assign halt_pc      = halt_pc_q;
  assign instr_count  = icnt_q;
  assign wdog_timeout = timeout_q;

endmodule
